diff_expand: RTL and testbench
==============================

# diff_expand

Multi-cycle inverse of the `diff` operation in the Grp55 RISC datapath. `diff` reports the index of the lowest bit where two words differ. This block takes a base word and a bit index, builds the one-hot mask serially, and returns the base word with that bit flipped. For any non-sentinel index, `diff(base, result)` therefore equals the supplied index. It sits beside the ALU as a handshaked functional unit, driven by the control FSM for diff-reconstruct instructions and for self-test of `diff`.

## Interface
- `WIDTH`, 32: data word width; fixed at 32 in this design.
- `IDXW`, 6: index width; matches the `diff` output width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `base`  in  32  operand word.
- `idx`  in  6  bit position to flip. 0–31 are valid; 32 means "no difference"; 33–63 are illegal.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  32  `base ^ mask`.
- `mask`  out  32  one-hot mask, or zero.
- `no_diff`  out  1  request had `idx == 32`.
- `idx_err`  out  1  request had `idx > 32`.

## Operation
- States: `IDLE`, `SHIFT`, `DONE`.
- `in_ready = (state == IDLE) && rst_n`.
- Accept when `in_valid && in_ready`. On accept, register `base`.
  - `idx < 32`: `mask_r <= 1`, `cnt <= idx[4:0]`, go to `SHIFT`.
  - `idx == 32`: `mask_r <= 0`, `no_diff <= 1`, go to `DONE`.
  - `idx > 32`: `mask_r <= 0`, `idx_err <= 1`, go to `DONE`.
- `SHIFT`:
  - If `cnt == 0`: `result_r <= base_r ^ mask_r`, go to `DONE`.
  - Else: `mask_r <= mask_r << 1`, `cnt <= cnt - 1`.
- Sentinel and illegal paths write `result_r <= base_r` on the accept edge.
- `DONE`:
  - `out_valid = 1`.
  - `result`, `mask`, `no_diff`, `idx_err` are held stable while `out_valid && !out_ready`.
  - On `out_ready`, go to `IDLE` and clear `no_diff`/`idx_err`.
- `cnt` is 5 bits. It never wraps, because it only decrements while nonzero.
- `mask` never has more than one bit set.
- `in_valid` while not `IDLE` is ignored. The requester must hold its request until `in_ready`.

## Timing
- Reset (async assert, synchronous release to `IDLE`): `state = IDLE`, and `in_ready`, `out_valid`, `result`, `mask`, `no_diff`, `idx_err`, `cnt` are all 0.
- Reset mid-operation aborts immediately with no output. The first accept is possible on the first edge after `rst_n` rises.
- Latency, counted from the accept edge to the first cycle with `out_valid` high:
  - `idx` 0–31: `idx + 2` cycles (`idx + 1` cycles in `SHIFT`, plus the entry edge into `DONE`).
  - `idx` ≥ 32: 1 cycle.
- Minimum spacing between accepts: latency + 1 cycle. `DONE` → `IDLE` costs one edge, and there is no accept during `DONE`.
- `out_valid` and `in_ready` are never high in the same cycle.
- If `out_ready` is already high when `DONE` is entered, the handshake completes on the first `DONE` cycle.

## Structure
- Shared package `grp55_pkg` holds:
  - `DIFF_W = 32`, `DIFF_IDXW = 6`.
  - `DIFF_IDX_NONE = 6'd32`.
  - State encodings `DX_IDLE = 2'd0`, `DX_SHIFT = 2'd1`, `DX_DONE = 2'd2`.
- Sub-module `mask_shifter`: the 32-bit mask register with load-one, load-zero and shift-left controls, plus the 5-bit down-counter and its `cnt_zero` flag.
- The top level holds the FSM, the base/result registers and the handshake logic.
- The XOR stage is plain logic; it does not instantiate `adder32`.

## Test plan
- Reset check: pulse `rst_n` low mid-`SHIFT` (`idx = 20`, cycle 5) → all outputs 0 asynchronously, `in_ready` is 1 on the first edge after release, and no `out_valid` follows.
- Basic flip: `base = 0x0000_00FF`, `idx = 3` → `out_valid` 5 cycles after accept, `result = 0x0000_00F7`, `mask = 0x0000_0008`, both flags 0.
- Top bit: `base = 0`, `idx = 31` → latency 33, `result = mask = 0x8000_0000`.
- Sentinel and illegal, issued back-to-back:
  - `idx = 32`, `base = 0xDEAD_BEEF` → latency 1, `result = 0xDEAD_BEEF`, `mask = 0`, `no_diff = 1`.
  - Then `idx = 45` → `idx_err = 1`, `mask = 0`.
- Backpressure: `idx = 0`, `out_ready` held low for 10 cycles → `out_valid` and `result = base ^ 1` stay stable, `in_valid` pulses are ignored, and `IDLE` is reached one cycle after `out_ready` rises.
- Round-trip: random `base` and `idx` in 0–31 over 1000 transactions, with `diff(base, result)` checked against `idx` → every transaction matches.

Source files
------------

// File: rtl/grp55_pkg.sv
// Shared Grp55 datapath constants and the diff_expand state encoding.
package grp55_pkg;

    localparam int DIFF_W    = 32;
    localparam int DIFF_IDXW = 6;
    localparam int DIFF_CNTW = 5;

    localparam logic [DIFF_IDXW-1:0] DIFF_IDX_NONE = 6'd32;

    typedef enum logic [1:0] {
        DX_IDLE  = 2'd0,
        DX_SHIFT = 2'd1,
        DX_DONE  = 2'd2
    } dx_state_e;

endpackage : grp55_pkg

// File: rtl/mask_shifter.sv
// One-hot mask register with load-one/load-zero/shift-left controls and the
// down-counter that decides how many more shifts are needed.
module mask_shifter
    import grp55_pkg::*;
#(
    parameter int WIDTH = DIFF_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_one_i,
    input  logic                 load_zero_i,
    input  logic                 shift_i,
    input  logic [DIFF_CNTW-1:0] cnt_i,
    output logic [WIDTH-1:0]     mask_o,
    output logic                 cnt_zero_o
);

    localparam logic [WIDTH-1:0] MASK_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     mask_q;
    logic [WIDTH-1:0]     mask_d;
    logic [DIFF_CNTW-1:0] cnt_q;
    logic [DIFF_CNTW-1:0] cnt_d;

    // Next-state selection: load wins over shift, otherwise hold.
    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        if (load_one_i) begin
            mask_d = MASK_ONE;
            cnt_d  = cnt_i;
        end else if (load_zero_i) begin
            mask_d = {WIDTH{1'b0}};
            cnt_d  = {DIFF_CNTW{1'b0}};
        end else if (shift_i) begin
            mask_d = mask_q << 1'b1;
            cnt_d  = cnt_q - 5'd1;
        end else begin
            mask_d = mask_q;
            cnt_d  = cnt_q;
        end
    end

    // Mask and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= {WIDTH{1'b0}};
            cnt_q  <= {DIFF_CNTW{1'b0}};
        end else begin
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mask_o     = mask_q;
    assign cnt_zero_o = (cnt_q == 5'd0);

endmodule : mask_shifter

// File: rtl/diff_expand.sv
// Inverse of diff: flips bit idx of base, building the one-hot mask serially.
// Handshaked on both sides; sentinel (32) and illegal (>32) indices finish in one edge.
module diff_expand
    import grp55_pkg::*;
#(
    parameter int WIDTH = DIFF_W,
    parameter int IDXW  = DIFF_IDXW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [IDXW-1:0]  idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mask,
    output logic             no_diff,
    output logic             idx_err
);

    dx_state_e        state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             no_diff_q, no_diff_d;
    logic             idx_err_q, idx_err_d;
    logic             out_valid_q;
    logic             load_one_s, load_zero_s, shift_s;
    logic             cnt_zero_s;
    logic [WIDTH-1:0] mask_s;
    logic             accept_s;

    assign in_ready = (state_q == DX_IDLE) && rst_n;
    assign accept_s = in_valid && in_ready;

    mask_shifter #(.WIDTH(WIDTH)) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_one_i (load_one_s),
        .load_zero_i(load_zero_s),
        .shift_i    (shift_s),
        .cnt_i      (idx[DIFF_CNTW-1:0]),
        .mask_o     (mask_s),
        .cnt_zero_o (cnt_zero_s)
    );

    // FSM next-state, datapath register updates and shifter controls.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        result_d    = result_q;
        no_diff_d   = no_diff_q;
        idx_err_d   = idx_err_q;
        load_one_s  = 1'b0;
        load_zero_s = 1'b0;
        shift_s     = 1'b0;
        case (state_q)
            DX_IDLE: begin
                if (accept_s) begin
                    base_d = base;
                    if (idx < DIFF_IDX_NONE) begin
                        load_one_s = 1'b1;
                        state_d    = DX_SHIFT;
                    end else begin
                        load_zero_s = 1'b1;
                        result_d    = base;
                        no_diff_d   = (idx == DIFF_IDX_NONE);
                        idx_err_d   = (idx > DIFF_IDX_NONE);
                        state_d     = DX_DONE;
                    end
                end else begin
                    state_d = DX_IDLE;
                end
            end
            DX_SHIFT: begin
                if (cnt_zero_s) begin
                    result_d = base_q ^ mask_s;
                    state_d  = DX_DONE;
                end else begin
                    shift_s = 1'b1;
                end
            end
            DX_DONE: begin
                if (out_ready) begin
                    no_diff_d = 1'b0;
                    idx_err_d = 1'b0;
                    state_d   = DX_IDLE;
                end else begin
                    state_d = DX_DONE;
                end
            end
            default: begin
                state_d = DX_IDLE;
            end
        endcase
    end

    // State and datapath registers; out_valid is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DX_IDLE;
            base_q      <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            no_diff_q   <= 1'b0;
            idx_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            result_q    <= result_d;
            no_diff_q   <= no_diff_d;
            idx_err_q   <= idx_err_d;
            out_valid_q <= (state_d == DX_DONE);
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign mask      = mask_s;
    assign no_diff   = no_diff_q;
    assign idx_err   = idx_err_q;

endmodule : diff_expand

// File: tb/tb_diff_expand.sv
// Directed bench for diff_expand: reset, flips, sentinel/illegal, backpressure,
// mid-operation reset and a randomised diff round-trip.
module tb_diff_expand;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base;
    logic [5:0]  idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] mask;
    logic        no_diff;
    logic        idx_err;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    diff_expand dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .base     (base),
        .idx      (idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .mask     (mask),
        .no_diff  (no_diff),
        .idx_err  (idx_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] b, input logic [5:0] i);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            step();
            g++;
        end
        chk("issue_ready", {31'd0, in_ready}, 32'd1);
        base     = b;
        idx      = i;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic finish_hs();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic int diff_f(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 32; k++) begin
            if (a[k] != b[k]) return k;
        end
        return 32;
    endfunction

    initial begin
        int lat;
        int hits;
        logic [31:0] rb;
        int ri;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        base      = 32'd0;
        idx       = 6'd0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_mask", mask, 32'd0);
        chk("rst_flags", {30'd0, no_diff, idx_err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // basic flip
        issue(32'h0000_00FF, 6'd3);
        wait_valid(lat);
        chk("flip_lat", lat, 32'd5);
        chk("flip_result", result, 32'h0000_00F7);
        chk("flip_mask", mask, 32'h0000_0008);
        chk("flip_flags", {30'd0, no_diff, idx_err}, 32'd0);
        chk("flip_not_ready", {31'd0, in_ready}, 32'd0);
        finish_hs();

        // top bit
        issue(32'h0000_0000, 6'd31);
        wait_valid(lat);
        chk("top_lat", lat, 32'd33);
        chk("top_result", result, 32'h8000_0000);
        chk("top_mask", mask, 32'h8000_0000);
        finish_hs();

        // sentinel then illegal, back-to-back
        issue(32'hDEAD_BEEF, 6'd32);
        wait_valid(lat);
        chk("none_lat", lat, 32'd1);
        chk("none_result", result, 32'hDEAD_BEEF);
        chk("none_mask", mask, 32'd0);
        chk("none_flags", {30'd0, no_diff, idx_err}, 32'd2);
        finish_hs();
        chk("none_cleared", {29'd0, out_valid, no_diff, idx_err}, 32'd0);
        issue(32'h0BAD_F00D, 6'd45);
        wait_valid(lat);
        chk("err_lat", lat, 32'd1);
        chk("err_result", result, 32'h0BAD_F00D);
        chk("err_mask", mask, 32'd0);
        chk("err_flags", {30'd0, no_diff, idx_err}, 32'd1);
        finish_hs();

        // backpressure with ignored requests
        issue(32'h1234_5678, 6'd0);
        wait_valid(lat);
        chk("bp_lat", lat, 32'd2);
        base = 32'hFFFF_FFFF;
        idx  = 6'd5;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            step();
            chk("bp_valid", {30'd0, out_valid, in_ready}, 32'd2);
            chk("bp_result", result, 32'h1234_5679);
            chk("bp_mask", mask, 32'h0000_0001);
        end
        in_valid = 1'b0;
        finish_hs();
        chk("bp_idle", {30'd0, out_valid, in_ready}, 32'd1);
        chk("bp_result_hold", result, 32'h1234_5679);

        // reset mid-SHIFT
        issue(32'hA5A5_A5A5, 6'd20);
        for (int c = 0; c < 4; c++) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {30'd0, out_valid, in_ready}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_mask", mask, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid) hits++;
        end
        chk("mid_rst_no_out", hits, 32'd0);

        // round-trip through diff
        for (int t = 0; t < 1000; t++) begin
            rb = $urandom;
            ri = $urandom_range(0, 31);
            issue(rb, ri[5:0]);
            wait_valid(lat);
            chk("rt_lat", lat, ri + 2);
            chk("rt_diff", diff_f(rb, result), ri);
            finish_hs();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule : tb_diff_expand
